// File: rtl/pwm.sv
// PWM generator: converts a frequency in Hz and a high time in microseconds into a
// registered pin waveform, using a usec prescaler, a bit-serial 1e6/freq divider and a usec period counter.
module pwm #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIV_W  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] freq,
  input  logic [15:0] duty_cycle_usec,
  output logic        pin
);
  localparam int CLKS_PER_USEC = CLK_HZ / 1_000_000;
  localparam int PRE_W = (CLKS_PER_USEC > 1) ? $clog2(CLKS_PER_USEC) : 1;
  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam int CMP_W = (DIV_W > 16) ? DIV_W : 16;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_USEC - 1);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(1_000_000);

  typedef enum logic {D_IDLE, D_BUSY} div_st_t;

  div_st_t          div_st_q, div_st_d;
  logic [15:0]      freq_last_q, freq_last_d;
  logic [16:0]      rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] period_next_q, period_next_d;
  logic             div_done_q, div_done_d;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] usec_cnt_q, usec_cnt_d;
  logic [DIV_W-1:0] period_usec_q, period_usec_d;
  logic [15:0]      duty_active_q, duty_active_d;
  logic             pin_q, pin_d;

  logic             usec_tick;
  logic [16:0]      rem_sh;

  assign usec_tick = (pre_cnt_q == PRE_LAST);
  // Remainder stays below the 16-bit divisor, so its top bit is always free for the shift.
  assign rem_sh    = {rem_q[15:0], quo_q[DIV_W-1]};

  always_comb begin
    div_st_d      = div_st_q;
    freq_last_d   = freq_last_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    bit_cnt_d     = bit_cnt_q;
    period_next_d = period_next_q;
    div_done_d    = 1'b0;
    case (div_st_q)
      D_IDLE: begin
        if (freq != freq_last_q) begin
          freq_last_d = freq;
          if (freq == 16'd0) begin
            period_next_d = '0;
          end else begin
            div_st_d  = D_BUSY;
            rem_d     = '0;
            quo_d     = DIVIDEND;
            bit_cnt_d = CNT_W'(DIV_W);
          end
        end
      end
      D_BUSY: begin
        // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
        if (rem_sh >= {1'b0, freq_last_q}) begin
          rem_d = rem_sh - {1'b0, freq_last_q};
          quo_d = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == CNT_W'(1)) begin
          div_st_d      = D_IDLE;
          period_next_d = quo_d;
          div_done_d    = 1'b1;
        end
      end
      default: div_st_d = D_IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d     = usec_tick ? '0 : pre_cnt_q + PRE_W'(1);
    usec_cnt_d    = usec_cnt_q;
    period_usec_d = period_usec_q;
    duty_active_d = duty_active_q;
    if (period_usec_q == '0) begin
      // Idle output: start a fresh period as soon as a quotient is available.
      if (div_done_q) begin
        period_usec_d = period_next_q;
        duty_active_d = duty_cycle_usec;
        usec_cnt_d    = '0;
        pre_cnt_d     = '0;
      end
    end else if (usec_tick) begin
      if (usec_cnt_q == period_usec_q - DIV_W'(1)) begin
        usec_cnt_d    = '0;
        period_usec_d = period_next_q;
        duty_active_d = duty_cycle_usec;
      end else begin
        usec_cnt_d = usec_cnt_q + DIV_W'(1);
      end
    end
    pin_d = (period_usec_q != '0) && (CMP_W'(usec_cnt_q) < CMP_W'(duty_active_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_st_q      <= D_IDLE;
      freq_last_q   <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      bit_cnt_q     <= '0;
      period_next_q <= '0;
      div_done_q    <= 1'b0;
      pre_cnt_q     <= '0;
      usec_cnt_q    <= '0;
      period_usec_q <= '0;
      duty_active_q <= '0;
      pin_q         <= 1'b0;
    end else begin
      div_st_q      <= div_st_d;
      freq_last_q   <= freq_last_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      bit_cnt_q     <= bit_cnt_d;
      period_next_q <= period_next_d;
      div_done_q    <= div_done_d;
      pre_cnt_q     <= pre_cnt_d;
      usec_cnt_q    <= usec_cnt_d;
      period_usec_q <= period_usec_d;
      duty_active_q <= duty_active_d;
      pin_q         <= pin_d;
    end
  end

  assign pin = pin_q;
endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm at 2 MHz: expected (high, low) clk counts per period are
// queued by the stimulus and popped by a monitor that measures pin edge spacing.
module tb_pwm;
  localparam int CLK_HZ = 2_000_000;
  localparam int CPU    = CLK_HZ / 1_000_000;

  typedef struct { int hi; int lo; } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] freq = '0;
  logic [15:0] duty = '0;
  logic        pin;

  pair_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  pwm #(.CLK_HZ(CLK_HZ), .DIV_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .freq(freq), .duty_cycle_usec(duty), .pin(pin)
  );

  always #5 clk = ~clk;

  // Monitor: a full period is rise -> fall -> rise; compare it to the queue head.
  int   cyc = 0, rise_t = 0, fall_t = 0, mst = 0;
  logic prev = 1'b0;
  always @(negedge clk) begin
    pair_t e;
    cyc++;
    if (!rst_n) begin
      mst  = 0;
      prev = 1'b0;
    end else begin
      if (pin && !prev) begin
        if (mst == 2 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp += 2;
          if (fall_t - rise_t != e.hi) begin
            n_bad++;
            $display("FAIL pair_high: got %0d clks want %0d", fall_t - rise_t, e.hi);
          end
          if (cyc - fall_t != e.lo) begin
            n_bad++;
            $display("FAIL pair_low: got %0d clks want %0d", cyc - fall_t, e.lo);
          end
        end
        rise_t = cyc;
        mst    = 1;
      end else if (!pin && prev && mst == 1) begin
        fall_t = cyc;
        mst    = 2;
      end
      prev = pin;
    end
  end

  // Reference: period = floor(1e6/f) usec, high = min(duty, period) usec.
  task automatic push(input int f, input int d, input int n);
    int per, h;
    per = 1_000_000 / f;
    h   = ((d < per) ? d : per) * CPU;
    for (int i = 0; i < n; i++) exp_q.push_back('{h, per * CPU - h});
  endtask

  task automatic drain(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout with %0d periods not seen", nm, exp_q.size());
    exp_q.delete();
  endtask

  task automatic do_reset(input int f, input int d);
    rst_n = 1'b0;
    freq  = 16'(f);
    duty  = 16'(d);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_const(input logic v, input int n, input string nm);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pin !== v) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: pin not %0b on %0d of %0d clks", nm, v, bad, n);
    end
  endtask

  task automatic check_pin(input logic v, input string nm);
    n_cmp++;
    if (pin !== v) begin
      n_bad++;
      $display("FAIL %s: pin=%0b want %0b", nm, pin, v);
    end
  endtask

  initial begin
    int f, d, per, waited;
    freq = 16'd400;
    repeat (2) @(negedge clk);
    check_pin(1'b0, "reset_pin");
    do_reset(400, 0);
    check_const(1'b0, 15100, "duty0_3periods");

    do_reset(400, 1000);
    push(400, 1000, 2);
    drain(12000, "f400_d1000");
    // Just past a period start: the running period keeps duty 1000.
    duty = 16'd2000;
    push(400, 1000, 1);
    push(400, 2000, 1);
    drain(11000, "duty_shadow");
    freq = 16'd1000;
    duty = 16'd300;
    push(400, 2000, 1);
    push(1000, 300, 3);
    drain(12000, "freq_shadow");

    waited = 0;
    while (pin !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check_pin(1'b1, "pin_high_before_reset");
    #2 rst_n = 1'b0;
    #1 check_pin(1'b0, "async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(1000, 300, 2);
    drain(5000, "restart_after_reset");

    do_reset(2000, 499);
    push(2000, 499, 2);
    drain(2500, "duty_per_minus_1");
    do_reset(2000, 1);
    push(2000, 1, 2);
    drain(2500, "duty_1");

    do_reset(2000, 3000);
    repeat (60) @(negedge clk);
    check_const(1'b1, 3000, "duty_gt_period");
    do_reset(2000, 500);
    repeat (60) @(negedge clk);
    check_const(1'b1, 2000, "duty_eq_period");

    do_reset(2000, 200);
    push(2000, 200, 1);
    drain(2500, "pre_freq0");
    freq = 16'd0;
    repeat (5) @(negedge clk);
    check_pin(1'b1, "freq0_period_finishes");
    repeat (1020) @(negedge clk);
    check_const(1'b0, 2000, "freq0_low");

    for (int k = 0; k < 6; k++) begin
      f   = $urandom_range(5000, 25000);
      per = 1_000_000 / f;
      d   = $urandom_range(1, per - 1);
      do_reset(f, d);
      push(f, d, 3);
      drain(4 * per * CPU + 200, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
